pipe_return_buffer: RTL and testbench

PIPE_RETURN_BUFFER -- requirements
Module: pipe_return_buffer

---
 rtl/pipe_return_buffer_if.sv | 30 +++
 rtl/pipe_return_buffer.sv | 115 +++++++++++
 tb/tb_pipe_return_buffer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_return_buffer_if.sv
// Handshake bundle between an upstream issuer, a fixed-latency external
// pipeline and the in-order return buffer that collects its results.
interface pipe_return_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  req_valid;
    logic                  issue_ok;
    logic                  ret_valid;
    logic [DATA_WIDTH-1:0] ret_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CNT_W-1:0]      inflight;
    logic                  err;

    // Issuer / pipeline / consumer side
    modport master (
        output req_valid, ret_valid, ret_data, out_ready,
        input  issue_ok, out_valid, out_data, inflight, err
    );

    // Buffer side
    modport slave (
        input  req_valid, ret_valid, ret_data, out_ready,
        output issue_ok, out_valid, out_data, inflight, err
    );
endinterface

// File: rtl/pipe_return_buffer.sv
// In-order return buffer for a fixed-latency external pipeline. Issues are
// only granted while buffered words plus outstanding requests fit in the
// buffer, so a compliant pipeline can never overflow it.
module pipe_return_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 4,
    parameter int DEPTH      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_return_buffer_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    // Reject parameter sets the credit scheme cannot honour.
    generate
        if (LATENCY < 1 || DEPTH < LATENCY || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
            $error("pipe_return_buffer: need LATENCY>=1, DEPTH>=LATENCY, DEPTH power of two");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] inflight_reg, inflight_next;
    logic             err_reg, err_next;

    logic issue;
    logic wr_en;
    logic overflow;
    logic pop;
    logic empty;

    // Credit check uses registered state only; a same-cycle pop is not counted.
    assign bus.issue_ok = ({1'b0, count_reg} + {1'b0, inflight_reg}) < {1'b0, DEPTH_C};
    assign issue        = bus.req_valid && bus.issue_ok;

    assign empty    = (count_reg == '0);
    assign wr_en    = bus.ret_valid && (count_reg != DEPTH_C);
    assign overflow = bus.ret_valid && (count_reg == DEPTH_C);
    assign pop      = !empty && bus.out_ready;

    // No bypass: a freshly written word shows up only from the next cycle.
    assign bus.out_valid = !empty;
    assign bus.out_data  = mem[rd_ptr_reg];
    assign bus.inflight  = inflight_reg;
    assign bus.err       = err_reg;

    // Storage write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= bus.ret_data;
        end
    end

    // Next-state for pointers, occupancy, outstanding count and error flag.
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        inflight_next = inflight_reg;
        err_next      = err_reg;

        if (wr_en) begin
            wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
        end

        case ({wr_en, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase

        // A dropped word is a protocol error.
        if (overflow) begin
            err_next = 1'b1;
        end

        // Issue and return in the same cycle cancel out.
        if (issue && !bus.ret_valid) begin
            inflight_next = inflight_reg + CNT_W'(1);
        end else if (!issue && bus.ret_valid) begin
            if (inflight_reg == '0) begin
                err_next = 1'b1;
            end else begin
                inflight_next = inflight_reg - CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            inflight_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            inflight_reg <= inflight_next;
            err_reg      <= err_next;
        end
    end
endmodule

// File: tb/tb_pipe_return_buffer.sv
// Directed bench for pipe_return_buffer with a LATENCY-cycle pipeline model
// that returns incrementing words exactly LATENCY cycles after each issue.
module tb_pipe_return_buffer;
    localparam int DW  = 8;
    localparam int LAT = 4;
    localparam int DEP = 8;

    logic clk;
    logic rst_n;

    pipe_return_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEP)) bus ();

    pipe_return_buffer #(.DATA_WIDTH(DW), .LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [LAT-1:0] hist;
    logic [DW-1:0]  ret_word;
    int             issue_total;

    // One clock cycle: record this cycle's issue, advance, then present the
    // pipeline return due in the next cycle.
    task automatic tick();
        logic did_issue;
        did_issue = bus.req_valid && bus.issue_ok;
        if (did_issue) issue_total++;
        @(posedge clk);
        #1;
        if (bus.ret_valid) ret_word = ret_word + 8'd1;
        hist          = {hist[LAT-2:0], did_issue};
        bus.ret_valid = hist[LAT-1];
        bus.ret_data  = ret_word;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        hist          = '0;
        bus.req_valid = 1'b0;
        bus.ret_valid = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        hist          = '0;
        ret_word      = '0;
        bus.req_valid = 1'b0;
        bus.ret_valid = 1'b0;
        bus.ret_data  = '0;
        bus.out_ready = 1'b0;
        #2;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        vectors++;
        if (bus.issue_ok !== 1'b1) begin miscompares++; $display("FAIL reset_issue_ok got=%b exp=1", bus.issue_ok); end
        vectors++;
        if (bus.inflight !== 4'd0) begin miscompares++; $display("FAIL reset_inflight got=%0d exp=0", bus.inflight); end
        vectors++;
        if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.issue_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset got valid=%b ok=%b exp valid=0 ok=1", bus.out_valid, bus.issue_ok);
        end
        $display("test_reset done");
    endtask

    task automatic test_streaming();
        logic    prev_ret;
        logic [DW-1:0] exp;
        exp           = '0;
        ret_word      = '0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            bus.req_valid = (c < 20);
            if (c < 20) begin
                vectors++;
                if (bus.issue_ok !== 1'b1) begin miscompares++; $display("FAIL stream_issue_ok c=%0d got=%b exp=1", c, bus.issue_ok); end
            end
            prev_ret = bus.ret_valid;
            tick();
            vectors++;
            if (bus.out_valid !== prev_ret) begin
                miscompares++;
                $display("FAIL stream_latency c=%0d got valid=%b exp=%b", c, bus.out_valid, prev_ret);
            end
            if (bus.out_valid === 1'b1) begin
                vectors++;
                if (bus.out_data !== exp) begin miscompares++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, bus.out_data, exp); end
                $display("stream word %h at cycle %0d", bus.out_data, c);
                exp = exp + 8'd1;
            end
        end
        vectors++;
        if (exp !== 8'd20) begin miscompares++; $display("FAIL stream_total got=%0d exp=20", exp); end
        vectors++;
        if (bus.err !== 1'b0 || bus.inflight !== 4'd0) begin
            miscompares++;
            $display("FAIL stream_end got err=%b inflight=%0d exp err=0 inflight=0", bus.err, bus.inflight);
        end
        bus.req_valid = 1'b0;
        $display("test_streaming done");
    endtask

    task automatic test_backpressure();
        ret_word      = '0;
        issue_total   = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            bus.req_valid = 1'b1;
            tick();
            vectors++;
            if (bus.issue_ok !== (c < 7)) begin
                miscompares++;
                $display("FAIL bp_issue_ok c=%0d got=%b exp=%b", c, bus.issue_ok, (c < 7));
            end
            if (bus.out_valid === 1'b1) begin
                vectors++;
                if (bus.out_data !== 8'h00) begin miscompares++; $display("FAIL bp_hold c=%0d got=%h exp=00", c, bus.out_data); end
            end
        end
        vectors++;
        if (issue_total !== 8) begin miscompares++; $display("FAIL bp_issues got=%0d exp=8", issue_total); end
        vectors++;
        if (bus.inflight !== 4'd0) begin miscompares++; $display("FAIL bp_inflight got=%0d exp=0", bus.inflight); end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i)) begin
                miscompares++;
                $display("FAIL bp_drain i=%0d got valid=%b data=%h exp valid=1 data=%h", i, bus.out_valid, bus.out_data, 8'(i));
            end
            $display("bp drain word %h", bus.out_data);
            tick();
        end
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.issue_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_after got valid=%b ok=%b exp valid=0 ok=1", bus.out_valid, bus.issue_ok);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] exp;
        exp      = '0;
        ret_word = '0;
        for (int c = 0; c < 11; c++) begin
            bus.req_valid = (c < 7);
            bus.out_ready = (c >= 7);
            if (c >= 7) begin
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
                    miscompares++;
                    $display("FAIL simul_pop c=%0d got valid=%b data=%h exp valid=1 data=%h", c, bus.out_valid, bus.out_data, exp);
                end
                $display("simul write+pop word %h", bus.out_data);
                exp = exp + 8'd1;
            end
            tick();
        end
        bus.out_ready = 1'b0;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
                miscompares++;
                $display("FAIL simul_drain i=%0d got valid=%b data=%h exp valid=1 data=%h", i, bus.out_valid, bus.out_data, exp);
            end
            bus.out_ready = 1'b1;
            tick();
            exp = exp + 8'd1;
        end
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_count got valid=%b err=%b exp valid=0 err=0", bus.out_valid, bus.err);
        end
        bus.out_ready = 1'b0;
        $display("test_simultaneous done");
    endtask

    task automatic test_unexpected();
        bus.ret_valid = 1'b1;
        bus.ret_data  = 8'hA5;
        tick();
        vectors++;
        if (bus.err !== 1'b1 || bus.inflight !== 4'd0) begin
            miscompares++;
            $display("FAIL unexp_err got err=%b inflight=%0d exp err=1 inflight=0", bus.err, bus.inflight);
        end
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL unexp_buffered got valid=%b data=%h exp valid=1 data=a5", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus.err !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL unexp_sticky got err=%b valid=%b exp err=1 valid=0", bus.err, bus.out_valid);
        end
        bus.out_ready = 1'b0;
        $display("test_unexpected done");
    endtask

    task automatic test_overflow();
        do_reset();
        ret_word = '0;
        for (int c = 0; c < 13; c++) begin
            bus.req_valid = 1'b1;
            tick();
        end
        bus.req_valid = 1'b0;
        vectors++;
        if (bus.err !== 1'b0 || bus.issue_ok !== 1'b0 || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_full got err=%b ok=%b valid=%b exp err=0 ok=0 valid=1", bus.err, bus.issue_ok, bus.out_valid);
        end
        bus.ret_valid = 1'b1;
        bus.ret_data  = 8'hEE;
        tick();
        vectors++;
        if (bus.err !== 1'b1 || bus.inflight !== 4'd0) begin
            miscompares++;
            $display("FAIL ovf_err got err=%b inflight=%0d exp err=1 inflight=0", bus.err, bus.inflight);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i)) begin
                miscompares++;
                $display("FAIL ovf_drain i=%0d got valid=%b data=%h exp valid=1 data=%h", i, bus.out_valid, bus.out_data, 8'(i));
            end
            tick();
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_dropped got valid=%b exp=0", bus.out_valid); end
        bus.out_ready = 1'b0;
        $display("test_overflow done");
    endtask

    task automatic test_mid_reset();
        do_reset();
        ret_word = '0;
        for (int c = 0; c < 7; c++) begin
            bus.req_valid = (c < 5);
            tick();
        end
        bus.req_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.inflight !== 4'd2) begin
            miscompares++;
            $display("FAIL mrst_pre got valid=%b inflight=%0d exp valid=1 inflight=2", bus.out_valid, bus.inflight);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.inflight !== 4'd0 || bus.issue_ok !== 1'b1 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL mrst_async got valid=%b inflight=%0d ok=%b err=%b exp 0/0/1/0",
                     bus.out_valid, bus.inflight, bus.issue_ok, bus.err);
        end
        tick();
        rst_n = 1'b1;
        vectors++;
        if (bus.err !== 1'b0) begin miscompares++; $display("FAIL mrst_err_held got=%b exp=0", bus.err); end
        tick();
        vectors++;
        if (bus.err !== 1'b1 || bus.inflight !== 4'd0) begin
            miscompares++;
            $display("FAIL mrst_stray got err=%b inflight=%0d exp err=1 inflight=0", bus.err, bus.inflight);
        end
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h04) begin
            miscompares++;
            $display("FAIL mrst_word got valid=%b data=%h exp valid=1 data=04", bus.out_valid, bus.out_data);
        end
        $display("test_mid_reset done");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        issue_total = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_unexpected();
        test_overflow();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
